bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter with synchronous load, wrap or saturate mode, and a registered terminal-event pulse.
- Successor to the fixed 3-digit cascaded up-counter. Adds digit-count parameter, count direction, preset load and overflow handling.
- Feeds seven-segment display drivers and timer/scoreboard logic. One instance replaces a chain of per-digit counters.

Parameters:
DIGITS, 3, number of BCD digits (1..8); counter value width is 4*DIGITS
WRAP, 1, 1 = wrap at limits (999->000, 000->999); 0 = saturate at limits
STEP_HOLD, 0, 1 = `en` must return low before the next count (edge-count mode); 0 = count every enabled cycle

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement; sampled with `en`
load  input  1  synchronous preset strobe
load_val  input  4*DIGITS  BCD preset value; digit k in bits [4k+3:4k]
num  output  4*DIGITS  current BCD value, registered; digit 0 is least significant
tc  output  1  registered one-cycle pulse on wrap or saturation event
sat  output  1  high while held at a limit in saturate mode
err  output  1  load-check error pulse (see Optional Feature; tied 0 when absent)

Behaviour:
- Reset, when `rst`=1 at an edge: `num`=0, `tc`=0, `sat`=0, `err`=0, edge-detect register=0.
- Priority per edge: `rst` > `load` > count > hold.
- Load: `num` <= `load_val` at that edge. `tc`=0 and `sat`=0 that cycle. Load takes effect even if `en`=1.
- Count qualifier:
  - STEP_HOLD=0: count when `en`=1.
  - STEP_HOLD=1: count only when `en`=1 and `en` was 0 on the previous edge. Edge register is updated every cycle, including during load.
- Latency: `num` reflects a qualified count on the same edge; visible one cycle after the `en` sample.
- Increment, per digit ripple within one cycle:
  - Digit 0 always steps.
  - Digit k steps only if all lower digits were 9.
  - A stepping digit of 9 becomes 0 with carry; otherwise it adds 1.
- Decrement, per digit ripple within one cycle:
  - Digit k steps only if all lower digits were 0.
  - A stepping digit of 0 becomes 9 with borrow; otherwise it subtracts 1.
- Upper limit event: all digits 9 and `up`=1.
  - WRAP=1: `num` becomes all 0 and `tc`=1 for one cycle.
  - WRAP=0: `num` holds all 9, `tc`=1 only on the first blocked count, `sat`=1.
- Lower limit event: all digits 0 and `up`=0. Same rules, with wrap to all 9s or hold at 0.
- `sat` clears on the first count in the opposite direction (value changes that edge), on load, or on reset.
- `tc` is 0 on every edge without a limit event, including hold cycles.
- Direction may change every cycle with no penalty.
- Reset mid-count discards the pending count. Reset asserted together with `load` gives 0.
- Invalid digits (>9) present without the check feature:
  - Increment treats any digit ≥9 as 9, so the result is 0 with carry.
  - Decrement subtracts 1 (e.g. C->B).
  - Limit detection uses exact 9/0 comparisons.

Optional Feature:
- Macro BCDCNT_LOAD_CHECK_EN.
- Defined:
  - At load, every digit of `load_val` greater than 9 is clamped to 9 before storing.
  - `err`=1 for exactly one cycle, on the load edge, if any digit was clamped; 0 otherwise.
  - `num` never holds an invalid digit.
- Undefined:
  - `load_val` is stored raw and `err` is constant 0.
  - Invalid-digit stepping follows the Behaviour rules.

Test Plan:
- DIGITS=3, WRAP=1, STEP_HOLD=0:
  - reset, then `en`=1, `up`=1 for 1000 cycles -> `num` steps 000..999 then 000.
  - `tc`=1 only on the 999->000 edge; 009->010 and 099->100 ripple in one cycle.
- DIGITS=3, WRAP=1, STEP_HOLD=0: load 000, `en`=1, `up`=0 -> `num`=999 next edge, `tc` pulse. Then 998, 997.
- DIGITS=3, WRAP=0, STEP_HOLD=0:
  - load 998, count up 3 cycles -> 999, 999, 999.
  - `tc` pulses once, on the 2nd edge; `sat`=1 from that edge.
  - One down count -> 998, `sat`=0.
- DIGITS=3, STEP_HOLD=1:
  - `en` held high 5 cycles from 000 -> `num`=001 only.
  - `en` toggled 1/0 four times -> 004.
- DIGITS=3: `load`=1 and `en`=1 with `load_val`=0x456 -> `num`=456 (load wins). `rst`=1 with `load`=1 -> 000.
- DIGITS=3, BCDCNT_LOAD_CHECK_EN defined: load 0x1A7 -> `num`=0x197, `err`=1 one cycle. Load 0x123 -> `err`=0.

Source files
------------

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter: synchronous load, wrap or saturate at limits, registered terminal pulse.
// Define BCDCNT_LOAD_CHECK_EN to clamp invalid load digits to 9 and flag the event on err.
module bcd_counter_n #(
  parameter int DIGITS    = 3,
  parameter int WRAP      = 1,
  parameter int STEP_HOLD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] num,
  output logic                tc,
  output logic                sat,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_num;
  logic         r_tc;
  logic         r_sat;
  logic         r_err;
  logic         r_en_d;

  logic [W-1:0] w_step;
  logic [W-1:0] w_load;
  logic         w_clamped;
  logic         w_all9;
  logic         w_all0;
  logic         w_limit;
  logic         w_count;

  // Ripple step across all digits in one cycle; any digit >= 9 carries on increment.
  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin : step_logic
    logic       c;
    logic [3:0] d;
    c      = 1'b1;
    d      = 4'd0;
    w_step = r_num;
    w_all9 = 1'b1;
    w_all0 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = r_num[4*k +: 4];
      if (d != 4'd9) w_all9 = 1'b0;
      if (d != 4'd0) w_all0 = 1'b0;
      if (c) begin
        if (up) begin
          if (d >= 4'd9) begin
            w_step[4*k +: 4] = 4'd0;
          end else begin
            w_step[4*k +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_step[4*k +: 4] = 4'd9;
          end else begin
            w_step[4*k +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_limit = up ? w_all9 : w_all0;
    if (STEP_HOLD != 0) w_count = en & ~r_en_d;
    else                w_count = en;
  end

`ifdef BCDCNT_LOAD_CHECK_EN
  always_comb begin
    w_load    = load_val;
    w_clamped = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        w_load[4*k +: 4] = 4'd9;
        w_clamped        = 1'b1;
      end
    end
  end
`else
  assign w_load    = load_val;
  assign w_clamped = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num  <= '0;
      r_tc   <= 1'b0;
      r_sat  <= 1'b0;
      r_err  <= 1'b0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= en;
      r_tc   <= 1'b0;
      r_err  <= 1'b0;
      if (load) begin
        r_num <= w_load;
        r_sat <= 1'b0;
        r_err <= w_clamped;
      end else if (w_count) begin
        if (w_limit) begin
          if (WRAP != 0) begin
            r_num <= w_step;
            r_tc  <= 1'b1;
          end else begin
            // Saturated: hold value, pulse tc only on the first blocked count.
            r_tc  <= ~r_sat;
            r_sat <= 1'b1;
          end
        end else begin
          r_num <= w_step;
          r_sat <= 1'b0;
        end
      end
    end
  end

  assign num = r_num;
  assign tc  = r_tc;
  assign sat = r_sat;
  assign err = r_err;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: three 3-digit instances (wrap, saturate, edge-count) share one stimulus stream
// and are compared every cycle against an arithmetic model, plus hand-computed literal checks.
module tb_bcd_counter_n;

  localparam int D = 3;
  localparam int W = 4 * D;
  // Instance i configuration: 0 = wrap, 1 = saturate, 2 = wrap + edge-count.
  localparam bit [2:0] CFG_WRAP = 3'b101;
  localparam bit [2:0] CFG_SH   = 3'b100;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] d_num [0:2];
  logic [2:0]   d_tc;
  logic [2:0]   d_sat;
  logic [2:0]   d_err;

  int n_vec  = 0;
  int n_miss = 0;

  bcd_counter_n #(.DIGITS(D), .WRAP(1), .STEP_HOLD(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .num(d_num[0]), .tc(d_tc[0]), .sat(d_sat[0]), .err(d_err[0]));

  bcd_counter_n #(.DIGITS(D), .WRAP(0), .STEP_HOLD(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .num(d_num[1]), .tc(d_tc[1]), .sat(d_sat[1]), .err(d_err[1]));

  bcd_counter_n #(.DIGITS(D), .WRAP(1), .STEP_HOLD(1)) u_edge (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .num(d_num[2]), .tc(d_tc[2]), .sat(d_sat[2]), .err(d_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] num;
    logic         tc;
    logic         sat;
    logic         err;
    logic         en_d;
  } mstate_t;

  mstate_t m [0:2];
  bit      model_ok = 1'b0;

  function automatic int bcd2int(logic [W-1:0] v);
    int r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit all_valid(logic [W-1:0] v);
    for (int k = 0; k < D; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Invalid-digit stepping: lowest digit that is not saturating absorbs the step.
  function automatic logic [W-1:0] raw_step(logic [W-1:0] v, logic u);
    logic [W-1:0] r;
    logic [3:0]   dg;
    r = v;
    for (int k = 0; k < D; k++) begin
      dg = v[4*k +: 4];
      if (u ? (dg < 4'd9) : (dg != 4'd0)) begin
        r[4*k +: 4] = u ? dg + 4'd1 : dg - 4'd1;
        return r;
      end
      r[4*k +: 4] = u ? 4'd0 : 4'd9;
    end
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit wrap, bit sh,
                                         logic r, logic ld, logic [W-1:0] lv, logic e, logic u);
    mstate_t      n;
    logic [W-1:0] nv;
    logic         clamped;
    n     = s;
    n.tc  = 1'b0;
    n.err = 1'b0;
    if (r) return '0;
    n.en_d = e;
    if (ld) begin
      nv      = lv;
      clamped = 1'b0;
`ifdef BCDCNT_LOAD_CHECK_EN
      for (int k = 0; k < D; k++) begin
        if (nv[4*k +: 4] > 4'd9) begin
          nv[4*k +: 4] = 4'd9;
          clamped      = 1'b1;
        end
      end
`endif
      n.num = nv;
      n.sat = 1'b0;
      n.err = clamped;
      return n;
    end
    if (!e || (sh && s.en_d)) return n;
    if (u ? (s.num == 12'h999) : (s.num == 12'h000)) begin
      if (wrap) begin
        n.num = u ? 12'h000 : 12'h999;
        n.tc  = 1'b1;
      end else begin
        n.tc  = !s.sat;
        n.sat = 1'b1;
      end
      return n;
    end
    n.sat = 1'b0;
    if (all_valid(s.num)) n.num = int2bcd(bcd2int(s.num) + (u ? 1 : -1));
    else                  n.num = raw_step(s.num, u);
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      m[i] = model_next(m[i], CFG_WRAP[i], CFG_SH[i], rst, load, load_val, en, up);
    if (rst) model_ok = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("num[%0d]", i), 32'(d_num[i]), 32'(m[i].num));
        check($sformatf("tc[%0d]", i),  32'(d_tc[i]),  32'(m[i].tc));
        check($sformatf("sat[%0d]", i), 32'(d_sat[i]), 32'(m[i].sat));
        check($sformatf("err[%0d]", i), 32'(d_err[i]), 32'(m[i].err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic ld, input logic [W-1:0] lv, input logic e, input logic u);
    rst      = r;
    load     = ld;
    load_val = lv;
    en       = e;
    up       = u;
    @(negedge clk);
  endtask

  initial begin
    int tc_cnt;

    cyc(1, 0, 12'h000, 0, 1);
    cyc(1, 0, 12'h000, 0, 1);
    check("reset num", 32'(d_num[0]), 32'h000);
    check("reset tc",  32'(d_tc[0]),  32'h0);
    check("reset sat", 32'(d_sat[1]), 32'h0);
    check("reset err", 32'(d_err[0]), 32'h0);

    // Full up sweep 000..999..000
    tc_cnt = 0;
    for (int i = 1; i <= 1000; i++) begin
      cyc(0, 0, 12'h000, 1, 1);
      if (d_tc[0]) tc_cnt++;
      if (i == 9)    check("up 009",      32'(d_num[0]), 32'h009);
      if (i == 10)   check("ripple 010",  32'(d_num[0]), 32'h010);
      if (i == 100)  check("ripple 100",  32'(d_num[0]), 32'h100);
      if (i == 999)  check("up 999",      32'(d_num[0]), 32'h999);
      if (i == 1000) begin
        check("wrap 000",    32'(d_num[0]), 32'h000);
        check("wrap tc",     32'(d_tc[0]),  32'h1);
        check("sat hold",    32'(d_num[1]), 32'h999);
        check("sat flag",    32'(d_sat[1]), 32'h1);
      end
    end
    check("tc pulse count", 32'(tc_cnt), 32'd1);
    check("edge held en", 32'(d_num[2]), 32'h001);

    // Down through zero
    cyc(0, 1, 12'h000, 0, 0);
    cyc(0, 0, 12'h000, 1, 0);
    check("down wrap 999", 32'(d_num[0]), 32'h999);
    check("down wrap tc",  32'(d_tc[0]),  32'h1);
    check("sat low hold",  32'(d_num[1]), 32'h000);
    cyc(0, 0, 12'h000, 1, 0);
    check("down 998", 32'(d_num[0]), 32'h998);
    cyc(0, 0, 12'h000, 1, 0);
    check("down 997", 32'(d_num[0]), 32'h997);

    // Saturate at top, then one count down
    cyc(0, 1, 12'h998, 0, 1);
    cyc(0, 0, 12'h000, 1, 1);
    check("sat e1 num", 32'(d_num[1]), 32'h999);
    check("sat e1 tc",  32'(d_tc[1]),  32'h0);
    cyc(0, 0, 12'h000, 1, 1);
    check("sat e2 tc",  32'(d_tc[1]),  32'h1);
    check("sat e2 sat", 32'(d_sat[1]), 32'h1);
    cyc(0, 0, 12'h000, 1, 1);
    check("sat e3 tc",  32'(d_tc[1]),  32'h0);
    check("sat e3 num", 32'(d_num[1]), 32'h999);
    cyc(0, 0, 12'h000, 1, 0);
    check("unsat num", 32'(d_num[1]), 32'h998);
    check("unsat sat", 32'(d_sat[1]), 32'h0);

    // Edge-count mode: four enable pulses
    cyc(0, 1, 12'h000, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 12'h000, 1, 1);
      cyc(0, 0, 12'h000, 0, 1);
    end
    check("edge toggles", 32'(d_num[2]), 32'h004);

    // Load priority and reset priority
    cyc(0, 1, 12'h456, 1, 1);
    check("load wins", 32'(d_num[0]), 32'h456);
    cyc(0, 0, 12'h000, 0, 1);
    check("hold tc", 32'(d_tc[0]), 32'h0);
    cyc(1, 1, 12'h456, 1, 1);
    check("rst over load", 32'(d_num[0]), 32'h000);

    // Invalid digits
    cyc(0, 1, 12'h1A9, 0, 1);
    cyc(0, 0, 12'h000, 1, 1);
    check("invalid up", 32'(d_num[0]), 32'h200);
    cyc(0, 1, 12'h0C0, 0, 0);
    cyc(0, 0, 12'h000, 1, 0);
`ifdef BCDCNT_LOAD_CHECK_EN
    check("invalid down", 32'(d_num[0]), 32'h089);
`else
    check("invalid down", 32'(d_num[0]), 32'h0B9);
`endif
    cyc(0, 1, 12'h1A7, 0, 0);
`ifdef BCDCNT_LOAD_CHECK_EN
    check("clamp num", 32'(d_num[0]), 32'h197);
    check("clamp err", 32'(d_err[0]), 32'h1);
`else
    check("raw num", 32'(d_num[0]), 32'h1A7);
    check("raw err", 32'(d_err[0]), 32'h0);
`endif
    cyc(0, 1, 12'h123, 0, 0);
    check("clean err", 32'(d_err[0]), 32'h0);

    // Direction change every cycle
    cyc(0, 1, 12'h500, 0, 1);
    cyc(0, 0, 12'h000, 1, 1);
    cyc(0, 0, 12'h000, 1, 0);
    cyc(0, 0, 12'h000, 1, 1);
    cyc(0, 0, 12'h000, 1, 1);
    cyc(0, 0, 12'h000, 1, 0);
    check("dir toggle", 32'(d_num[0]), 32'h501);

    // Reset mid-count
    cyc(1, 0, 12'h000, 1, 1);
    check("rst mid-count", 32'(d_num[0]), 32'h000);
    cyc(0, 0, 12'h000, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
